// File: rtl/seg7_pkg.sv
// ============================================================================
// Module      : seg7_pkg
// Description : Shared types, segment table and helpers for the 3-digit
//               multiplexed seven-segment display with binary-to-BCD front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  typedef enum logic [1:0] {
    DIG_UNITS    = 2'd0,
    DIG_TENS     = 2'd1,
    DIG_HUNDREDS = 2'd2
  } digit_e;

  // Active-low {g,f,e,d,c,b,a} codes for decimal digits 0..9.
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic int scan_div(input int clk_hz, input int scan_hz);
    return clk_hz / scan_hz;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] nib);
    logic [6:0] code;
    code = SEG_BLANK;
    if (nib <= 4'd9) code = SEG_TABLE[nib];
    return code;
  endfunction

  // Double-dabble correction applied to every BCD nibble before a shift.
  function automatic logic [11:0] bcd_add3(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    for (int i = 0; i < 3; i++) begin
      if (v[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential 8-bit binary to 3-digit BCD converter, one bit per
//               clock, MSB first; result register changes only on completion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic [11:0] bcd,
  output logic        done,
  output logic        busy
);

  conv_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [11:0] work_q, work_d;
  logic [11:0] bcd_q, bcd_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [11:0] adj;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      work_q  <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      work_q  <= work_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    work_d  = work_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    adj     = bcd_add3(work_q);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d = bin;
          work_d  = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        work_d  = {adj[10:0], shift_q[7]};
        shift_d = {shift_q[6:0], 1'b0};
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = ST_DONE;
      end
      ST_DONE: begin
        bcd_d   = work_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bcd  = bcd_q;
  assign done = done_q;
  assign busy = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: rtl/seg7_scan_display.sv
// ============================================================================
// Module      : seg7_scan_display
// Description : Converts an 8-bit count to BCD and scans it onto a 3-digit
//               active-low seven-segment display with leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int SCAN_HZ = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] q,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       busy
);

  localparam int              SCAN_DIV = scan_div(CLK_HZ, SCAN_HZ);
  localparam int              PRE_W    = $clog2(SCAN_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);

  logic [7:0]       last_q_q, last_q_d;
  logic [11:0]      disp_q, disp_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  digit_e           digit_q, digit_d;
  logic [6:0]       seg_q, seg_d;
  logic [2:0]       an_q, an_d;
  logic             conv_start, conv_done, conv_busy;
  logic [11:0]      conv_bcd;
  logic [3:0]       h, t, u;

  assign conv_start = (q != last_q_q) && !conv_busy;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (q),
    .bcd   (conv_bcd),
    .done  (conv_done),
    .busy  (conv_busy)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q_q <= '0;
      disp_q   <= '0;
      pre_q    <= '0;
      digit_q  <= DIG_UNITS;
      seg_q    <= SEG_BLANK;
      an_q     <= 3'b111;
    end else begin
      last_q_q <= last_q_d;
      disp_q   <= disp_d;
      pre_q    <= pre_d;
      digit_q  <= digit_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  // seg/an are built from next-state values so both change on one edge.
  always_comb begin
    last_q_d = conv_start ? q : last_q_q;
    disp_d   = conv_done ? conv_bcd : disp_q;
    pre_d    = (pre_q == PRE_MAX) ? '0 : pre_q + PRE_W'(1);
    digit_d  = digit_q;
    if (pre_q == PRE_MAX) begin
      case (digit_q)
        DIG_UNITS: digit_d = DIG_TENS;
        DIG_TENS:  digit_d = DIG_HUNDREDS;
        default:   digit_d = DIG_UNITS;
      endcase
    end
    h     = disp_d[11:8];
    t     = disp_d[7:4];
    u     = disp_d[3:0];
    an_d  = 3'b111;
    seg_d = SEG_BLANK;
    case (digit_d)
      DIG_UNITS: begin
        an_d  = 3'b110;
        seg_d = seg_code(u);
      end
      DIG_TENS: begin
        an_d  = 3'b101;
        seg_d = (h == 4'd0 && t == 4'd0) ? SEG_BLANK : seg_code(t);
      end
      DIG_HUNDREDS: begin
        an_d  = 3'b011;
        seg_d = (h == 4'd0) ? SEG_BLANK : seg_code(h);
      end
      default: begin
        an_d  = 3'b111;
        seg_d = SEG_BLANK;
      end
    endcase
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign busy = conv_busy;

endmodule

`default_nettype wire
